// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage: passes non-memory results straight through,
// and turns loads/stores into a single bus transaction while stalling the pipeline.
// Word accesses must be 4-byte aligned; misalignment and bus timeouts raise a
// sticky error and complete with a zero result.
module load_store_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MEM_ld,
  input  logic            MEM_str,
  input  logic            MEM_byt,
  input  logic [XLEN-1:0] MEM_alu_out,
  input  logic [XLEN-1:0] MEM_b2,
  output logic [XLEN-1:0] MEM_data_mem,
  output logic            stall_M,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            lsu_err
);

  // Counter covers 0 .. TIMEOUT-1 REQ cycles.
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic              byt_q, byt_d;
  logic              ld_q, ld_d;
  logic [1:0]        off_q, off_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              err_q, err_d;

  logic              mem_op;
  logic              misaligned;
  logic [XLEN-1:0]   lane_shift;
  logic [XLEN-1:0]   load_val;

  assign mem_op     = MEM_ld | MEM_str;
  assign misaligned = ~MEM_byt & (MEM_alu_out[1:0] != 2'b00);

  // Byte loads return the addressed lane, zero-extended.
  assign lane_shift = bus_rdata >> {off_q, 3'b000};
  assign load_val   = byt_q ? {{(XLEN - 8){1'b0}}, lane_shift[7:0]} : bus_rdata;

  // Bus request attributes come straight from the captured registers so they stay stable.
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign bus_we    = we_q;
  assign lsu_err   = err_q;

  // Next-state, capture and output decode.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    byt_d        = byt_q;
    ld_d         = ld_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    err_d        = err_q;
    stall_M      = 1'b0;
    bus_req      = 1'b0;
    MEM_data_mem = '0;

    unique case (state_q)
      StIdle: begin
        MEM_data_mem = MEM_alu_out;
        if (mem_op) begin
          stall_M  = 1'b1;
          cnt_d    = '0;
          result_d = '0;
          ld_d     = MEM_ld;
          byt_d    = MEM_byt;
          off_d    = MEM_alu_out[1:0];
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = {MEM_alu_out[XLEN-1:2], 2'b00};
            // A simultaneous load+store is handled as a load.
            we_d    = ~MEM_ld;
            be_d    = MEM_byt ? (4'b0001 << MEM_alu_out[1:0]) : 4'b1111;
            wdata_d = MEM_byt ? {(XLEN / 8){MEM_b2[7:0]}} : MEM_b2;
            state_d = StReq;
          end
        end
      end

      StReq: begin
        stall_M = 1'b1;
        bus_req = 1'b1;
        if (bus_ack) begin
          result_d = ld_q ? load_val : '0;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StDone: begin
        MEM_data_mem = result_q;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and capture registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      byt_q    <= 1'b0;
      ld_q     <= 1'b0;
      off_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      byt_q    <= byt_d;
      ld_q     <= ld_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset corner sequences and
// randomized operations checked against a transaction-level reference model.
module tb_load_store_unit;

  localparam int TO = 15;

  logic        clk;
  logic        rst;
  logic        MEM_ld;
  logic        MEM_str;
  logic        MEM_byt;
  logic [31:0] MEM_alu_out;
  logic [31:0] MEM_b2;
  logic [31:0] MEM_data_mem;
  logic        stall_M;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        lsu_err;

  int n_chk;
  int n_fail;
  logic err_model;

  typedef struct {
    logic        ld;
    logic        str;
    logic        byt;
    logic [31:0] addr;
    logic [31:0] b2;
    logic [31:0] rdata;
    int          ack_dly;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
    logic        e_err;
  } vec_t;

  vec_t tbl[9];

  load_store_unit #(
    .XLEN   (32),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .MEM_ld      (MEM_ld),
    .MEM_str     (MEM_str),
    .MEM_byt     (MEM_byt),
    .MEM_alu_out (MEM_alu_out),
    .MEM_b2      (MEM_b2),
    .MEM_data_mem(MEM_data_mem),
    .stall_M     (stall_M),
    .bus_req     (bus_req),
    .bus_we      (bus_we),
    .bus_addr    (bus_addr),
    .bus_be      (bus_be),
    .bus_wdata   (bus_wdata),
    .bus_ack     (bus_ack),
    .bus_rdata   (bus_rdata),
    .lsu_err     (lsu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic str, input logic byt,
                              input logic [31:0] addr, input logic [31:0] b2,
                              input logic [31:0] rdata, input int ack_dly,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic e_we, input logic [31:0] e_wdata,
                              input logic [31:0] e_res, input logic e_err);
    vec_t v;
    v.ld = ld; v.str = str; v.byt = byt; v.addr = addr; v.b2 = b2; v.rdata = rdata;
    v.ack_dly = ack_dly; v.e_addr = e_addr; v.e_be = e_be; v.e_we = e_we;
    v.e_wdata = e_wdata; v.e_res = e_res; v.e_err = e_err;
    return v;
  endfunction

  // Reference model: derives the expected transaction from the access description.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit mis;
    bit tmo;
    r = v;
    mis = !v.byt && (v.addr % 4 != 0);
    tmo = v.ack_dly >= TO;
    r.e_addr  = v.addr - (v.addr % 4);
    r.e_be    = v.byt ? 4'(1 << (v.addr % 4)) : 4'hF;
    r.e_we    = v.str && !v.ld;
    r.e_wdata = v.byt ? (v.b2 & 32'hFF) * 32'h0101_0101 : v.b2;
    if (mis || tmo || r.e_we) r.e_res = 0;
    else if (v.byt) r.e_res = (v.rdata / (32'd1 << (8 * (v.addr % 4)))) % 256;
    else r.e_res = v.rdata;
    err_model = err_model | mis | tmo;
    r.e_err = err_model;
    return r;
  endfunction

  // Runs one memory op from the IDLE capture cycle through DONE.
  task automatic do_op(input vec_t v);
    bit mis;
    bit acked;
    mis = !v.byt && (v.addr[1:0] != 2'b00);
    @(negedge clk);
    MEM_ld = v.ld; MEM_str = v.str; MEM_byt = v.byt;
    MEM_alu_out = v.addr; MEM_b2 = v.b2; bus_ack = 1'b0;
    #1;
    chk("capture_stall", 32'(stall_M), 32'd1);
    chk("capture_noreq", 32'(bus_req), 32'd0);
    if (!mis) begin
      acked = 1'b0;
      for (int k = 0; k < TO && !acked; k++) begin
        @(negedge clk);
        MEM_alu_out = $urandom;
        MEM_b2      = $urandom;
        bus_ack     = (k == v.ack_dly);
        bus_rdata   = bus_ack ? v.rdata : $urandom;
        #1;
        chk("req_req", 32'(bus_req), 32'd1);
        chk("req_stall", 32'(stall_M), 32'd1);
        chk("req_addr", bus_addr, v.e_addr);
        chk("req_be", 32'(bus_be), 32'(v.e_be));
        chk("req_we", 32'(bus_we), 32'(v.e_we));
        if (v.e_we) chk("req_wdata", bus_wdata, v.e_wdata);
        acked = bus_ack;
      end
    end
    @(negedge clk);
    bus_ack = 1'b0; MEM_ld = 1'b0; MEM_str = 1'b0; MEM_alu_out = $urandom;
    #1;
    chk("done_stall", 32'(stall_M), 32'd0);
    chk("done_noreq", 32'(bus_req), 32'd0);
    chk("done_data", MEM_data_mem, v.e_res);
    chk("done_err", 32'(lsu_err), 32'(v.e_err));
  endtask

  initial begin
    vec_t v;
    n_chk = 0;
    n_fail = 0;
    err_model = 1'b0;

    //        ld str byt addr          b2            rdata         dly e_addr        be      we e_wdata       e_res         err
    tbl[0] = mk(1, 0, 1, 32'h0000_0006, 32'h0,        32'hAABB_CCDD, 0, 32'h0000_0004, 4'b0100, 0, 32'h0,        32'h0000_00BB, 0);
    tbl[1] = mk(0, 1, 1, 32'h0000_0003, 32'h0000_005A, 32'h0,        3, 32'h0000_0000, 4'b1000, 1, 32'h5A5A_5A5A, 32'h0,        0);
    tbl[2] = mk(1, 0, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1, 32'h0000_0100, 4'b1111, 0, 32'h0,        32'hDEAD_BEEF, 0);
    tbl[3] = mk(0, 1, 0, 32'h0000_002C, 32'h1234_5678, 32'h0,        0, 32'h0000_002C, 4'b1111, 1, 32'h1234_5678, 32'h0,        0);
    tbl[4] = mk(1, 1, 0, 32'h0000_0040, 32'hFFFF_FFFF, 32'hCAFE_F00D, 2, 32'h0000_0040, 4'b1111, 0, 32'h0,        32'hCAFE_F00D, 0);
    tbl[5] = mk(1, 0, 1, 32'h0000_0000, 32'h0,        32'h1122_3344, 0, 32'h0000_0000, 4'b0001, 0, 32'h0,        32'h0000_0044, 0);
    tbl[6] = mk(1, 0, 1, 32'h0000_0007, 32'h0,        32'h80FF_0000, 1, 32'h0000_0004, 4'b1000, 0, 32'h0,        32'h0000_0080, 0);
    tbl[7] = mk(0, 1, 0, 32'h0000_0002, 32'h0,        32'h0,         0, 32'h0,         4'b0000, 1, 32'h0,        32'h0,        1);
    tbl[8] = mk(1, 0, 0, 32'h0000_0010, 32'h0,        32'h0,        99, 32'h0000_0010, 4'b1111, 0, 32'h0,        32'h0,        1);

    rst = 1'b0; MEM_ld = 1'b0; MEM_str = 1'b0; MEM_byt = 1'b0;
    MEM_alu_out = '0; MEM_b2 = '0; bus_ack = 1'b0; bus_rdata = '0;
    #3;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_stall", 32'(stall_M), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Passthrough for non-memory instructions.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      MEM_alu_out = (i == 0) ? 32'h0000_1234 : $urandom;
      #1;
      chk("pass_data", MEM_data_mem, MEM_alu_out);
      chk("pass_stall", 32'(stall_M), 32'd0);
      chk("pass_req", 32'(bus_req), 32'd0);
    end

    // Directed table, including the misalignment and timeout error cases.
    for (int i = 0; i < 9; i++) do_op(tbl[i]);
    err_model = 1'b1;

    // Asynchronous reset in the middle of a request, then a stray ack.
    @(negedge clk);
    MEM_ld = 1'b1; MEM_byt = 1'b0; MEM_alu_out = 32'h0000_0020;
    @(negedge clk);
    #1;
    chk("mid_req_active", 32'(bus_req), 32'd1);
    #2;
    MEM_ld = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus_req), 32'd0);
    chk("mid_rst_err", 32'(lsu_err), 32'd0);
    chk("mid_rst_be", 32'(bus_be), 32'd0);
    chk("mid_rst_addr", bus_addr, 32'd0);
    err_model = 1'b0;
    @(negedge clk);
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA; MEM_alu_out = 32'h0000_0077;
    #1;
    chk("late_ack_stall", 32'(stall_M), 32'd0);
    chk("late_ack_req", 32'(bus_req), 32'd0);
    chk("late_ack_data", MEM_data_mem, 32'h0000_0077);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("late_ack_idle_req", 32'(bus_req), 32'd0);
    chk("late_ack_idle_stall", 32'(stall_M), 32'd0);
    chk("late_ack_idle_err", 32'(lsu_err), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(1, 3));
      v.ld = op[0];
      v.str = op[1];
      v.byt = 1'($urandom_range(0, 1));
      v.addr = $urandom;
      if (!v.byt && $urandom_range(0, 9) != 0) v.addr[1:0] = 2'b00;
      v.b2 = $urandom;
      v.rdata = $urandom;
      v.ack_dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      do_op(model(v));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
